// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bin2bcd_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int BCD_ADJ_THRESH = 5;
  localparam int BCD_ADJ_ADD    = 3;
  localparam int N_DEF          = 18;
  localparam int DIGITS_DEF     = 6;
endpackage

// File: rtl/bin2bcd_converter_digit_adjust.sv
// Double-dabble digit correction: one BCD digit, +3 when it would overflow on the next shift.
module bcd_digit_adjust
  import bin2bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'(BCD_ADJ_THRESH)) ? din + 4'(BCD_ADJ_ADD) : din;
endmodule

// File: rtl/bin2bcd_converter.sv
// Sequential double-dabble converter: one binary bit per clock, held BCD result, one-cycle done pulse.
module bin2bcd_converter
  import bin2bcd_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N-1:0]          bin,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int CW = $clog2(N + 1);
  localparam int BW = 4 * DIGITS;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    sr_q, sr_d;
  logic [BW-1:0]   work_q, work_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [BW-1:0]   adj;
  logic [BW-1:0]   shifted;
  logic            adj_msb_unused;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .din  (work_q[4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  // The adjusted top bit is always 0 when 10^DIGITS covers 2^N-1, so it falls off the shift.
  assign shifted        = {adj[BW-2:0], sr_q[N-1]};
  assign adj_msb_unused = adj[BW-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    work_d  = work_q;
    bcd_d   = bcd_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d    = bin;
          work_d  = '0;
          cnt_d   = CW'(N);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        work_d = shifted;
        sr_d   = {sr_q[N-2:0], 1'b0};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = shifted;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      work_q  <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      work_q  <= work_d;
      bcd_q   <= bcd_d;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign bcd   = bcd_q;
endmodule

// File: tb/tb_bin2bcd_converter.sv
// Randomized and directed bench for bin2bcd_converter against a decimal-arithmetic reference model.
module tb_bin2bcd_converter;
  localparam int N      = 18;
  localparam int DIGITS = 6;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [N-1:0]       bin_drv = '0;
  logic               use_cntr = 1'b0;
  logic               en = 1'b0;
  logic [N-1:0]       cntr;
  logic [N-1:0]       bin;
  logic               ready, done;
  logic [4*DIGITS-1:0] bcd;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  assign bin = use_cntr ? cntr : bin_drv;

  always #5 clk = ~clk;

  bin2bcd_converter #(.N(N), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .ready(ready), .done(done), .bcd(bcd)
  );

  // Upstream binary_counter stand-in
  always @(posedge clk or posedge rst)
    if (rst) cntr <= '0;
    else if (en) cntr <= cntr + 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: cycles remaining until back in idle; result known from the accepted value.
  int                  m_rem = 0;
  int                  m_val = 0;
  logic [4*DIGITS-1:0] m_bcd = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem = 0;
      m_bcd = '0;
    end else if (m_rem == 0) begin
      if (start) begin
        m_val = int'(bin);
        m_rem = N + 1;
      end
    end else begin
      m_rem--;
      if (m_rem == 1) m_bcd = to_bcd(m_val);
    end
  end

  always @(negedge clk) begin
    check("ready", 32'(ready), 32'(m_rem == 0));
    check("done",  32'(done),  32'(m_rem == 1));
    check("bcd",   32'(bcd),   32'(m_bcd));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!ready && k < 40) begin tick(); k++; end
    check("wait_ready_timeout", 32'(ready), 32'd1);
  endtask

  task automatic convert(input int val, input logic [4*DIGITS-1:0] exp, input string nm);
    int e;
    wait_ready();
    bin_drv = N'(val);
    start   = 1'b1;
    tick();
    start   = 1'b0;
    e = 0;
    while (!done && e < 40) begin tick(); e++; end
    check({nm, "_latency"}, 32'(e), 32'(N));
    check({nm, "_bcd"}, 32'(bcd), 32'(exp));
    check({nm, "_no_ready_with_done"}, 32'(ready), 32'd0);
    tick();
    check({nm, "_ready_after"}, 32'(ready), 32'd1);
    check({nm, "_done_cleared"}, 32'(done), 32'd0);
  endtask

  initial begin
    int cnt, last, k;
    #1;
    check("rst_bcd",   32'(bcd),   32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done",  32'(done),  32'd0);
    check("model_pin_262143", 32'(to_bcd(262143)), 32'h262143);
    check("model_pin_99999",  32'(to_bcd(99999)),  32'h099999);
    tick(); tick();
    rst = 1'b0;

    convert(0,      24'h000000, "zero");
    convert(262143, 24'h262143, "full");
    convert(99999,  24'h099999, "n99999");
    convert(1,      24'h000001, "one");
    convert(10,     24'h000010, "ten");

    // Second request while busy must be dropped
    wait_ready();
    bin_drv = N'(1234); start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    bin_drv = N'(555); start = 1'b1; tick(); start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 45; i++) begin tick(); if (done) cnt++; end
    check("busy_done_count", 32'(cnt), 32'd1);
    check("busy_bcd", 32'(bcd), 32'h001234);

    // Counter-driven, start held high
    wait_ready();
    use_cntr = 1'b1; en = 1'b1; start = 1'b1;
    cnt = 0; last = -1; k = 0;
    while (cnt < 10 && k < 300) begin
      tick(); k++;
      if (done) begin
        if (last >= 0) check("cntr_period", 32'(cyc - last), 32'd20);
        last = cyc;
        cnt++;
      end
    end
    check("cntr_conversions", 32'(cnt), 32'd10);
    start = 1'b0; en = 1'b0; use_cntr = 1'b0;

    // Randomized start/bin traffic, including requests during busy
    wait_ready();
    for (int i = 0; i < 800; i++) begin
      bin_drv = N'($urandom_range(0, 262143));
      start   = ($urandom_range(0, 3) == 0);
      tick();
    end
    start = 1'b0;

    // Asynchronous reset in the middle of a conversion
    wait_ready();
    bin_drv = N'(54321); start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    #1 rst = 1'b1;
    #1;
    check("midrst_bcd",   32'(bcd),   32'd0);
    check("midrst_done",  32'(done),  32'd0);
    check("midrst_ready", 32'(ready), 32'd1);
    tick(); tick();
    rst = 1'b0;
    convert(42, 24'h000042, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
